// File: rtl/code2_ctrl_pkg.sv
// code2 issue controller shared definitions.
// Instruction field layout, usage decode and FSM states.
package code2_ctrl_pkg;

  localparam int I_W = 24;
  localparam int R_W = 5;
  localparam int F_W = 3;

  localparam int OP_BIT = 0;
  localparam int F3_LO  = 1;
  localparam int RS_LO  = F_W + 1;
  localparam int RT_LO  = R_W + F_W + 1;
  localparam int RD_LO  = 2 * R_W + F_W + 1;

  localparam logic [F_W-1:0] F3_LOAD   = 3'b000;
  localparam logic [F_W-1:0] F3_STORE  = 3'b001;
  localparam logic [F_W-1:0] F3_BRANCH = 3'b010;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  typedef struct packed {
    logic rs_used;
    logic rt_used;
    logic writes;
  } use_t;

  function automatic logic [R_W-1:0] rs_of(
    input logic [I_W-1:0] instr
  );
    return instr[RS_LO +: R_W];
  endfunction

  function automatic logic [R_W-1:0] rt_of(
    input logic [I_W-1:0] instr
  );
    return instr[RT_LO +: R_W];
  endfunction

  function automatic logic [R_W-1:0] rd_of(
    input logic [I_W-1:0] instr
  );
    return instr[RD_LO +: R_W];
  endfunction

  // STORE and BRANCH read both sources but write nothing;
  // LOAD and the remaining op=1 forms read rs only.
  function automatic use_t decode_use(
    input logic [I_W-1:0] instr
  );
    logic           op;
    logic [F_W-1:0] f3;
    use_t           u;
    op = instr[OP_BIT];
    f3 = instr[F3_LO +: F_W];
    u  = '0;
    unique case (1'b1)
      !op: u = '{1'b1, 1'b1, 1'b1};
      op && (f3 == F3_STORE || f3 == F3_BRANCH):
        u = '{1'b1, 1'b1, 1'b0};
      default: u = '{1'b1, 1'b0, 1'b1};
    endcase
    return u;
  endfunction

endpackage

// File: rtl/code2_issue_ctrl_scoreboard.sv
// code2 register scoreboard.
// Busy bit per register plus pending-write counter.
module code2_scoreboard
  import code2_ctrl_pkg::*;
#(
  parameter int R    = R_W,
  parameter int NREG = 2 ** R,
  parameter int MAXO = 4,
  parameter int CW   = $clog2(MAXO + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_i,
  input  logic [R-1:0]    set_addr_i,
  input  logic            clr_i,
  input  logic [R-1:0]    clr_addr_i,
  output logic [NREG-1:0] busy_o,
  output logic            full_o,
  output logic [CW-1:0]   count_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            clr_ok;

  assign clr_ok  = clr_i & busy_q[clr_addr_i];
  assign busy_o  = busy_q;
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(MAXO));

  // Apply set and effective clear; a writeback to an idle reg is dropped.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (set_i)
      busy_d[set_addr_i] = 1'b1;
    if (clr_ok)
      busy_d[clr_addr_i] = 1'b0;
    unique case ({set_i, clr_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/code2_issue_ctrl.sv
// code2 decode issue/hazard controller.
// Issue decision, drain FSM, scoreboard hookup.
module code2_issue_ctrl
  import code2_ctrl_pkg::*;
#(
  parameter int I    = I_W,
  parameter int R    = R_W,
  parameter int F    = F_W,
  parameter int NREG = 2 ** R,
  parameter int MAXO = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [I-1:0]               instr_i,
  input  logic                       instr_valid_i,
  input  logic                       ex_ready_i,
  input  logic                       flush_i,
  input  logic                       wb_we_i,
  input  logic [R-1:0]               wb_wa_i,
  input  logic                       drain_i,
  output logic                       issue_o,
  output logic                       bubble_o,
  output logic                       stall_o,
  output logic                       drained_o,
  output logic [NREG-1:0]            busy_o,
  output logic [$clog2(MAXO+1)-1:0]  outstanding_o,
  output logic [1:0]                 state_o
);

  localparam int CW = $clog2(MAXO + 1);

  state_t         state_q;
  state_t         state_d;
  use_t           u;
  logic [R-1:0]   rs;
  logic [R-1:0]   rt;
  logic [R-1:0]   rd;
  logic           full;
  logic           hazard;
  logic           wb_hit;
  logic           cnt_zero_d;
  logic [CW-1:0]  cnt;
  logic [NREG-1:0] busy;

  assign u  = decode_use(instr_i);
  assign rs = rs_of(instr_i);
  assign rt = rt_of(instr_i);
  assign rd = rd_of(instr_i);

  assign hazard = (u.rs_used & busy[rs])
                | (u.rt_used & busy[rt])
                | (u.writes  & busy[rd])
                | (u.writes  & full);

  assign issue_o = (state_q == RUN) & instr_valid_i
                 & ~hazard & ex_ready_i & ~flush_i;
  assign bubble_o  = ~issue_o;
  assign stall_o   = instr_valid_i & ~issue_o & ~flush_i;
  assign drained_o = (state_q == DRAINED);

  assign busy_o        = busy;
  assign outstanding_o = cnt;
  assign state_o       = state_q;

  code2_scoreboard #(
    .R    (R),
    .NREG (NREG),
    .MAXO (MAXO),
    .CW   (CW)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (issue_o & u.writes),
    .set_addr_i (rd),
    .clr_i      (wb_we_i),
    .clr_addr_i (wb_wa_i),
    .busy_o     (busy),
    .full_o     (full),
    .count_o    (cnt)
  );

  // No issue happens outside RUN, so only a retiring write can lower cnt.
  assign wb_hit     = wb_we_i & busy[wb_wa_i];
  assign cnt_zero_d = (cnt == '0) | ((cnt == CW'(1)) & wb_hit);

  // Drain sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_i)    state_d = DRAIN;
      DRAIN:   if (cnt_zero_d) state_d = DRAINED;
      DRAINED: if (!drain_i)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

endmodule

// File: tb/tb_code2_issue_ctrl.sv
// Directed bench for code2_issue_ctrl.
// Hand-computed vectors, one task per scenario.
module tb_code2_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [23:0] instr_i;
  logic        instr_valid_i;
  logic        ex_ready_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_wa_i;
  logic        drain_i;
  logic        issue_o;
  logic        bubble_o;
  logic        stall_o;
  logic        drained_o;
  logic [31:0] busy_o;
  logic [2:0]  outstanding_o;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  code2_issue_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .ex_ready_i    (ex_ready_i),
    .flush_i       (flush_i),
    .wb_we_i       (wb_we_i),
    .wb_wa_i       (wb_wa_i),
    .drain_i       (drain_i),
    .issue_o       (issue_o),
    .bubble_o      (bubble_o),
    .stall_o       (stall_o),
    .drained_o     (drained_o),
    .busy_o        (busy_o),
    .outstanding_o (outstanding_o),
    .state_o       (state_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [23:0] alu(
    input int rd, input int rs, input int rt
  );
    logic [23:0] v;
    v = 24'(rd) << 14 | 24'(rt) << 9 | 24'(rs) << 4;
    return v;
  endfunction

  task automatic test_reset();
    rst_i = 1; instr_i = '0; instr_valid_i = 0;
    ex_ready_i = 1; flush_i = 0; wb_we_i = 0;
    wb_wa_i = '0; drain_i = 0;
    cyc(); cyc();
    checks++;
    if (busy_o !== 32'h0 || outstanding_o !== 3'd0
        || state_o !== 2'd0 || drained_o !== 1'b0) begin
      failures++;
      $display("FAIL reset busy=%h out=%0d st=%0d dr=%b want 0/0/0/0",
               busy_o, outstanding_o, state_o, drained_o);
    end
    rst_i = 0;
    #1;
  endtask

  task automatic test_independent();
    instr_i = 24'h00C410; instr_valid_i = 1;
    #1;
    checks++;
    if ({issue_o, bubble_o, stall_o} !== 3'b100) begin
      failures++;
      $display("FAIL indep_issue got=%b want=100",
               {issue_o, bubble_o, stall_o});
    end
    cyc();
    instr_valid_i = 0;
    #1;
    checks++;
    if (busy_o !== 32'h8 || outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL indep_sb busy=%h out=%0d want 8/1",
               busy_o, outstanding_o);
    end
  endtask

  task automatic test_raw();
    instr_i = 24'h014830; instr_valid_i = 1;
    #1;
    checks++;
    if ({issue_o, bubble_o, stall_o} !== 3'b011) begin
      failures++;
      $display("FAIL raw_stall got=%b want=011",
               {issue_o, bubble_o, stall_o});
    end
    cyc();
    wb_we_i = 1; wb_wa_i = 5'd3;
    #1;
    checks++;
    if (issue_o !== 1'b0 || stall_o !== 1'b1) begin
      failures++;
      $display("FAIL raw_no_bypass issue=%b stall=%b want 0/1",
               issue_o, stall_o);
    end
    cyc();
    wb_we_i = 0;
    #1;
    checks++;
    if (issue_o !== 1'b1 || busy_o[3] !== 1'b0
        || outstanding_o !== 3'd0) begin
      failures++;
      $display("FAIL raw_release issue=%b b3=%b out=%0d want 1/0/0",
               issue_o, busy_o[3], outstanding_o);
    end
    cyc();
    instr_valid_i = 0;
    wb_we_i = 1; wb_wa_i = 5'd5;
    cyc();
    wb_we_i = 0;
    #1;
    checks++;
    if (busy_o !== 32'h0 || outstanding_o !== 3'd0) begin
      failures++;
      $display("FAIL raw_retire busy=%h out=%0d want 0/0",
               busy_o, outstanding_o);
    end
  endtask

  task automatic test_limit();
    for (int k = 1; k <= 4; k++) begin
      instr_i = alu(k, 0, 0); instr_valid_i = 1;
      #1;
      checks++;
      if (issue_o !== 1'b1) begin
        failures++;
        $display("FAIL limit_fill%0d issue=%b want 1", k, issue_o);
      end
      cyc();
    end
    instr_i = alu(5, 0, 0);
    #1;
    checks++;
    if (outstanding_o !== 3'd4 || issue_o !== 1'b0
        || stall_o !== 1'b1) begin
      failures++;
      $display("FAIL limit_full out=%0d issue=%b stall=%b want 4/0/1",
               outstanding_o, issue_o, stall_o);
    end
    wb_we_i = 1; wb_wa_i = 5'd1;
    #1;
    checks++;
    if (issue_o !== 1'b0) begin
      failures++;
      $display("FAIL limit_same_cyc issue=%b want 0", issue_o);
    end
    cyc();
    wb_we_i = 0;
    #1;
    checks++;
    if (issue_o !== 1'b1 || outstanding_o !== 3'd3) begin
      failures++;
      $display("FAIL limit_free issue=%b out=%0d want 1/3",
               issue_o, outstanding_o);
    end
    cyc();
    instr_valid_i = 0;
    for (int k = 3; k <= 5; k++) begin
      wb_we_i = 1; wb_wa_i = 5'(k);
      cyc();
    end
    wb_we_i = 0;
    #1;
    checks++;
    if (busy_o !== 32'h4 || outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL limit_drainback busy=%h out=%0d want 4/1",
               busy_o, outstanding_o);
    end
  endtask

  task automatic test_flush();
    instr_i = alu(7, 0, 0); instr_valid_i = 1; flush_i = 1;
    #1;
    checks++;
    if ({issue_o, bubble_o, stall_o} !== 3'b010) begin
      failures++;
      $display("FAIL flush_out got=%b want=010",
               {issue_o, bubble_o, stall_o});
    end
    cyc();
    flush_i = 0; instr_valid_i = 0;
    #1;
    checks++;
    if (busy_o !== 32'h4 || outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL flush_sb busy=%h out=%0d want 4/1",
               busy_o, outstanding_o);
    end
  endtask

  task automatic test_simul();
    instr_i = alu(6, 0, 0); instr_valid_i = 1;
    wb_we_i = 1; wb_wa_i = 5'd2;
    #1;
    checks++;
    if (issue_o !== 1'b1) begin
      failures++;
      $display("FAIL simul_issue issue=%b want 1", issue_o);
    end
    cyc();
    wb_we_i = 0; instr_valid_i = 0;
    #1;
    checks++;
    if (busy_o !== 32'h40 || outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL simul_sb busy=%h out=%0d want 40/1",
               busy_o, outstanding_o);
    end
    instr_i = alu(7, 0, 0); instr_valid_i = 1;
    cyc();
    instr_valid_i = 0;
  endtask

  task automatic test_drain();
    instr_i = alu(8, 0, 0); instr_valid_i = 1; drain_i = 1;
    #1;
    checks++;
    if (issue_o !== 1'b1 || outstanding_o !== 3'd2) begin
      failures++;
      $display("FAIL drain_first issue=%b out=%0d want 1/2",
               issue_o, outstanding_o);
    end
    cyc();
    instr_i = alu(9, 0, 0);
    #1;
    checks++;
    if (state_o !== 2'd1 || issue_o !== 1'b0 || stall_o !== 1'b1
        || outstanding_o !== 3'd3 || drained_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_enter st=%0d iss=%b stl=%b out=%0d dr=%b",
               state_o, issue_o, stall_o, outstanding_o, drained_o);
    end
    instr_valid_i = 0;
    wb_we_i = 1; wb_wa_i = 5'd6;
    cyc();
    wb_wa_i = 5'd7;
    cyc();
    #1;
    checks++;
    if (state_o !== 2'd1 || outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL drain_wait st=%0d out=%0d want 1/1",
               state_o, outstanding_o);
    end
    wb_wa_i = 5'd8;
    cyc();
    wb_we_i = 0;
    #1;
    checks++;
    if (state_o !== 2'd2 || drained_o !== 1'b1
        || outstanding_o !== 3'd0) begin
      failures++;
      $display("FAIL drain_done st=%0d dr=%b out=%0d want 2/1/0",
               state_o, drained_o, outstanding_o);
    end
    instr_valid_i = 1; instr_i = alu(9, 0, 0);
    cyc();
    checks++;
    if (state_o !== 2'd2 || issue_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_hold st=%0d issue=%b want 2/0",
               state_o, issue_o);
    end
    drain_i = 0;
    cyc();
    checks++;
    if (state_o !== 2'd0 || drained_o !== 1'b0
        || issue_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_exit st=%0d dr=%b issue=%b want 0/0/1",
               state_o, drained_o, issue_o);
    end
    instr_valid_i = 0;
    #1;
  endtask

  task automatic test_reset_mid_drain();
    instr_i = alu(10, 0, 0); instr_valid_i = 1;
    cyc();
    instr_i = alu(11, 0, 0); drain_i = 1;
    cyc();
    instr_valid_i = 0;
    #1;
    checks++;
    if (state_o !== 2'd1 || outstanding_o !== 3'd2) begin
      failures++;
      $display("FAIL rstmid_pre st=%0d out=%0d want 1/2",
               state_o, outstanding_o);
    end
    rst_i = 1;
    cyc();
    rst_i = 0; drain_i = 0;
    #1;
    checks++;
    if (busy_o !== 32'h0 || outstanding_o !== 3'd0
        || state_o !== 2'd0 || drained_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid busy=%h out=%0d st=%0d dr=%b want 0/0/0/0",
               busy_o, outstanding_o, state_o, drained_o);
    end
  endtask

  task automatic test_decode_ready();
    instr_i = alu(5, 0, 0); instr_valid_i = 1; ex_ready_i = 0;
    #1;
    checks++;
    if ({issue_o, bubble_o, stall_o} !== 3'b011) begin
      failures++;
      $display("FAIL exready_low got=%b want=011",
               {issue_o, bubble_o, stall_o});
    end
    ex_ready_i = 1;
    cyc();
    instr_i = 24'h014003;
    #1;
    checks++;
    if (issue_o !== 1'b1) begin
      failures++;
      $display("FAIL store_no_waw issue=%b want 1", issue_o);
    end
    cyc();
    checks++;
    if (outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL store_no_set out=%0d want 1", outstanding_o);
    end
    instr_i = 24'h000A01;
    #1;
    checks++;
    if (issue_o !== 1'b1) begin
      failures++;
      $display("FAIL load_rt_unused issue=%b want 1", issue_o);
    end
    cyc();
    instr_i = 24'h000A00;
    #1;
    checks++;
    if (issue_o !== 1'b0 || stall_o !== 1'b1) begin
      failures++;
      $display("FAIL alu_rt_raw issue=%b stall=%b want 0/1",
               issue_o, stall_o);
    end
    instr_valid_i = 0;
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_limit();
    test_flush();
    test_simul();
    test_drain();
    test_reset_mid_drain();
    test_decode_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code2_issue_ctrl.md
# code2_issue_ctrl

Issue/hazard controller for the code2 decode stage. It sits between fetch and the code2 decode-to-execute pipe register. It keeps a register scoreboard of pending writes and decides each cycle whether the instruction in decode issues, or whether a bubble goes down the pipe while fetch/decode stall. It also sequences a drain so the datapath can be quiesced before key or config changes.

## Interface
- `I`, 24, instruction width
- `R`, 5, register address width
- `F`, 3, funct3 width
- `NREG`, 2**R, number of architectural registers tracked
- `MAXO`, 4, maximum outstanding register writes in flight (1..2**R)
- `clk_i`  in  1  clock; the only clock, all state changes on its rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `instr_i`  in  I  instruction in decode; fields: [0] op, [F:1] funct3, [R+F:F+1] rs, [2R+F:R+F+1] rt, [3R+F:2R+F+1] rd
- `instr_valid_i`  in  1  instr_i holds a real instruction
- `ex_ready_i`  in  1  execute stage can accept an instruction this cycle
- `flush_i`  in  1  kill the decode instruction this cycle (taken branch)
- `wb_we_i`  in  1  writeback writes regfile this cycle (same signal as regfile we3)
- `wb_wa_i`  in  R  writeback register address (regfile wa3)
- `drain_i`  in  1  request quiesce
- `issue_o`  out  1  decode instruction transfers to execute this cycle
- `bubble_o`  out  1  pipe register loads a NOP this cycle
- `stall_o`  out  1  hold fetch PC and decode instruction
- `drained_o`  out  1  drain complete, nothing outstanding
- `busy_o`  out  NREG  scoreboard, bit n = write to rn pending
- `outstanding_o`  out  $clog2(MAXO+1)  count of pending writes
- `state_o`  out  2  FSM state encoding

## Operation
- Instruction decode into usage:
  - op=0 (ALU, any funct3): reads rs and rt, writes rd.
  - op=1, funct3=000 (LOAD): reads rs, writes rd.
  - op=1, funct3=001 (STORE): reads rs and rt, no write.
  - op=1, funct3=010 (BRANCH): reads rs and rt, no write.
  - op=1, other funct3: reads rs, writes rd.
- All NREG registers are tracked; r0 gets no special treatment.
- hazard = (rs used & busy[rs]) | (rt used & busy[rt]) | (writes & busy[rd]) | (writes & outstanding==MAXO). The busy[rd] term blocks WAW.
- issue_o = state==RUN & instr_valid_i & !hazard & ex_ready_i & !flush_i.
- bubble_o = !issue_o.
- stall_o = instr_valid_i & !issue_o & !flush_i.
- On an issue that writes rd: busy[rd] is set and outstanding is incremented.
- On wb_we_i with busy[wb_wa_i]=1: that bit is cleared and outstanding is decremented.
- wb_we_i to a non-busy register is ignored.
- Issue and writeback in the same cycle: both updates apply, so outstanding is net unchanged. They cannot target the same register, because issue requires busy[rd]=0.
- Flush suppresses issue only. It does not touch the scoreboard, and in-flight writes still retire.
- FSM states:
  - RUN=0: normal issue. If drain_i=1, go to DRAIN next cycle. Issue is still allowed in the cycle drain_i is first sampled.
  - DRAIN=1: issue_o=0. When outstanding==0 (after that cycle's update), go to DRAINED.
  - DRAINED=2: issue_o=0, drained_o=1. When drain_i=0, go to RUN.
  - drained_o=0 in every other state.

## Timing
- Outputs issue_o, bubble_o and stall_o are combinational from registered state plus the current-cycle inputs. This module adds zero cycles of latency.
- Scoreboard updates take effect on the next edge. There is no same-cycle writeback bypass: an instruction waiting on rn issues no earlier than the cycle after wb_we_i for rn.
- Back-to-back dependent ALU ops therefore stall until writeback of the producer, plus one cycle.
- Reset values, including reset mid-operation:
  - busy_o=0, outstanding_o=0, state=RUN, drained_o=0.
  - issue_o follows the combinational inputs.
  - All in-flight scoreboard state is discarded.
- ex_ready_i=0 keeps the instruction in decode: stall_o=1, bubble_o=1.

## Structure
- Package code2_ctrl_pkg holds:
  - field offset constants for op/funct3/rs/rt/rd;
  - funct3 constants LOAD, STORE, BRANCH;
  - state enum {RUN, DRAIN, DRAINED};
  - function `decode_use(instr)` returning the rs_used, rt_used and writes flags.
- Sub-module code2_scoreboard holds the NREG busy vector and the outstanding counter. It has set/clear ports and exposes busy and full (outstanding==MAXO).
- The top level holds the FSM and the issue logic.

## Test plan
- Independent ALU op. instr=0x00C410 (r3←r1,r2), valid, ex_ready=1 → issue_o=1 that cycle; next cycle busy_o[3]=1, outstanding=1.
- RAW hazard. Issue 0x00C410, then present 0x014830 (rs=r3) → stall_o=1 and bubble_o=1 until wb_we_i with wb_wa_i=3. Issue happens exactly one cycle after that writeback; busy_o[3]=0 at that point.
- Outstanding limit. Issue 4 independent writers (rd=1..4, MAXO=4), then a 5th writer to rd=5 → stalls. One writeback frees it the next cycle.
- Flush and simultaneous events:
  - flush_i with a hazard-free instruction → issue_o=0, stall_o=0, scoreboard unchanged.
  - Issue to rd=6 in the same cycle as writeback of rd=2 → outstanding unchanged, busy[6]=1, busy[2]=0.
- Drain and reset:
  - drain_i with 2 outstanding → DRAIN, issue_o=0; after 2 writebacks → drained_o=1; drain_i=0 → RUN.
  - rst_i asserted mid-DRAIN → next cycle busy_o=0, outstanding_o=0, state RUN.
